pst_wb: RTL and testbench
=========================

# pst_wb

Write-back stage of the pipelined core. It latches the MEM-stage result into the MEM/WB pipeline register and selects the register-file write data. It drives the register-file write port of the decode stage: write enable, write index and write data. It also retires syscalls: it updates the display latch, and enters a sticky halt state on the exit syscall.

## Interface
- Parameters
  - `SYSCALL_EXIT`, default 10: `$v0` value that halts the core.
- Ports
  - `clk` in 1: core clock, rising edge.
  - `rst_n` in 1: reset, asynchronous, active-low.
  - `en` in 1: pipeline advance. Retire and load happen only on edges with `en`=1.
  - `mem_valid` in 1: MEM slot holds a real instruction (0 = bubble).
  - `mem_ctl_rf_we` in 1: instruction writes the register file.
  - `mem_val_rf_req_w` in 5: destination register index.
  - `mem_sel_rf_w_pc_4` in 1: write data = PC+4.
  - `mem_sel_rf_w_dm` in 1: write data = data-memory read.
  - `mem_pc_4` in 32: PC+4 of the instruction.
  - `mem_alu_data` in 32: ALU result.
  - `mem_dm_data` in 32: data-memory read data.
  - `mem_syscall_en` in 1: instruction is a syscall.
  - `mem_rf_data_a` in 32: `$v0` value, valid when `mem_syscall_en`=1.
  - `mem_rf_data_b` in 32: `$a0` value, valid when `mem_syscall_en`=1.
  - `ctl_rf_we` out 1: register-file write enable.
  - `val_rf_req_w` out 5: register-file write index.
  - `val_rf_data_w` out 32: register-file write data.
  - `halt` out 1: core halted (sticky).
  - `disp_data` out 32: last displayed `$a0`.
  - `cnt_retired` out 32: count of retired instructions.

## Operation
- WB register fields: valid, we, req_w, wdata, syscall, v0, a0. Reset clears all of them to 0.
- Write data is selected at load time:
  - `mem_sel_rf_w_pc_4`=1 gives `mem_pc_4`. This has priority over dm.
  - Otherwise `mem_sel_rf_w_dm`=1 gives `mem_dm_data`.
  - Otherwise the data is `mem_alu_data`.
- The loaded we is `mem_valid & mem_ctl_rf_we & (mem_val_rf_req_w != 0)`. Register 0 is never written.
- Outputs are driven directly from the WB register:
  - `ctl_rf_we` = valid & we.
  - `val_rf_req_w` = req_w.
  - `val_rf_data_w` = wdata.
- FSM states: RUN and HALT. Reset state is RUN.
- In RUN, on an edge with `en`=1, the resident instruction retires:
  - Counter: if valid, `cnt_retired` += 1. The counter wraps modulo 2^32.
  - Halt: if valid & syscall & v0==`SYSCALL_EXIT`, the state becomes HALT and the WB register loads a bubble (the incoming instruction is squashed).
  - Display: if valid & syscall & v0!=`SYSCALL_EXIT`, `disp_data` <= a0.
  - Load: unless the halt case applies, the WB register loads the MEM inputs.
- In HALT:
  - `en` is ignored.
  - The WB register stays a bubble, so `ctl_rf_we`=0.
  - `disp_data` and `cnt_retired` hold.
  - Only `rst_n` leaves HALT.
- `halt` = (state==HALT).
- When `en`=0, all state holds and the outputs are stable.

## Timing
- Reset values: all outputs are 0; the state is RUN.
- Reset is asynchronous and takes effect immediately, including in the middle of a halt or in the middle of a stall.
- Latency:
  - MEM inputs are captured at edge N (with `en`=1).
  - `ctl_rf_we`/`val_rf_req_w`/`val_rf_data_w` are valid after edge N.
  - The register file commits the write at the next `en`=1 edge.
- `halt` rises after the edge at which the exit syscall retires. No register write from any later instruction is ever presented.
- `disp_data` updates at the same edge at which the display syscall retires.
- A syscall writes no register. Decode guarantees we=0 for syscalls.

## Configuration
- `WB_RETIRE_CNT_EN`:
  - When defined: the 32-bit retired counter is implemented as described above.
  - When undefined: no counter register exists and `cnt_retired` is tied to 0.
  - All other behaviour is identical in both builds.

## Test plan
- ALU write: load `mem_ctl_rf_we`=1, req_w=8, alu=0x1234, sel=0/0 with en=1.
  - After the edge: `ctl_rf_we`=1, `val_rf_req_w`=8, `val_rf_data_w`=0x1234.
- Mux priority: sel_pc_4=1 and sel_dm=1, pc_4=0x3004, dm=0xBEEF. Required: wdata=0x3004.
- $zero write: req_w=0 with we=1. Required: `ctl_rf_we`=0.
- Stall: en=0 for 3 cycles while the WB register holds a valid instruction.
  - Outputs hold.
  - `cnt_retired` is unchanged until the next en=1 edge, then increments by 1.
- Syscall display, then exit:
  - First syscall: v0=1, a0=0xCAFE. Required: `disp_data`=0xCAFE after its retire edge.
  - Then syscall v0=10 followed by an ALU write to r9.
  - Required: `halt`=1, r9 write never asserted, `ctl_rf_we` stays 0 with en toggling.
- Reset mid-halt: assert `rst_n`=0 asynchronously while halted.
  - Required: `halt`=0, `disp_data`=0 and `cnt_retired`=0 immediately.
  - Normal writes resume after release.

Source files
------------

// File: rtl/pst_wb.sv
// Write-back stage: MEM/WB register, register-file write port, syscall retire (display latch, sticky exit halt).
// Optional macro WB_RETIRE_CNT_EN enables the 32-bit retired-instruction counter; otherwise cnt_retired is tied to 0.
module pst_wb #(
  parameter logic [31:0] SYSCALL_EXIT = 32'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        mem_valid,
  input  logic        mem_ctl_rf_we,
  input  logic [4:0]  mem_val_rf_req_w,
  input  logic        mem_sel_rf_w_pc_4,
  input  logic        mem_sel_rf_w_dm,
  input  logic [31:0] mem_pc_4,
  input  logic [31:0] mem_alu_data,
  input  logic [31:0] mem_dm_data,
  input  logic        mem_syscall_en,
  input  logic [31:0] mem_rf_data_a,
  input  logic [31:0] mem_rf_data_b,
  output logic        ctl_rf_we,
  output logic [4:0]  val_rf_req_w,
  output logic [31:0] val_rf_data_w,
  output logic        halt,
  output logic [31:0] disp_data,
  output logic [31:0] cnt_retired
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic        vld_p0;
  logic        we_p0;
  logic        sys_p0;
  logic [4:0]  req_p0;
  logic [31:0] wdata_p0;
  logic [31:0] v0_p0;
  logic [31:0] a0_p0;
  logic        retire;
  logic        exit_ret;

  // PC+4 wins over the data-memory read, which wins over the ALU result.
  function automatic logic [31:0] sel_wdata(input logic sel_pc_4, input logic sel_dm,
                                            input logic [31:0] pc_4, input logic [31:0] dm,
                                            input logic [31:0] alu);
    if (sel_pc_4)    return pc_4;
    else if (sel_dm) return dm;
    else             return alu;
  endfunction

  assign retire   = (state == RUN) && en;
  assign exit_ret = vld_p0 && sys_p0 && (v0_p0 == SYSCALL_EXIT);

  // MEM -> WB boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      vld_p0    <= 1'b0;
      we_p0     <= 1'b0;
      sys_p0    <= 1'b0;
      req_p0    <= '0;
      wdata_p0  <= '0;
      v0_p0     <= '0;
      a0_p0     <= '0;
      disp_data <= '0;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (exit_ret) begin
              // The exit syscall squashes whatever follows it.
              state    <= HALT;
              vld_p0   <= 1'b0;
              we_p0    <= 1'b0;
              sys_p0   <= 1'b0;
              req_p0   <= '0;
              wdata_p0 <= '0;
              v0_p0    <= '0;
              a0_p0    <= '0;
            end else begin
              if (vld_p0 && sys_p0) disp_data <= a0_p0;
              vld_p0   <= mem_valid;
              we_p0    <= mem_valid && mem_ctl_rf_we && (mem_val_rf_req_w != 5'd0);
              sys_p0   <= mem_syscall_en;
              req_p0   <= mem_val_rf_req_w;
              wdata_p0 <= sel_wdata(mem_sel_rf_w_pc_4, mem_sel_rf_w_dm,
                                    mem_pc_4, mem_dm_data, mem_alu_data);
              v0_p0    <= mem_rf_data_a;
              a0_p0    <= mem_rf_data_b;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_p0 <= '0;
    else if (retire && vld_p0) cnt_p0 <= cnt_p0 + 32'd1;
  end

  assign cnt_retired = cnt_p0;
`else
  assign cnt_retired = '0;
`endif

  assign ctl_rf_we     = vld_p0 && we_p0;
  assign val_rf_req_w  = req_p0;
  assign val_rf_data_w = wdata_p0;
  assign halt          = (state == HALT);

endmodule

// File: tb/tb_pst_wb.sv
// Randomized and directed bench for pst_wb, checked against a behavioural retire/halt model.
module tb_pst_wb;

  localparam logic [31:0] EXIT = 32'd10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mem_valid;
  logic        mem_ctl_rf_we;
  logic [4:0]  mem_val_rf_req_w;
  logic        mem_sel_rf_w_pc_4;
  logic        mem_sel_rf_w_dm;
  logic [31:0] mem_pc_4;
  logic [31:0] mem_alu_data;
  logic [31:0] mem_dm_data;
  logic        mem_syscall_en;
  logic [31:0] mem_rf_data_a;
  logic [31:0] mem_rf_data_b;
  logic        ctl_rf_we;
  logic [4:0]  val_rf_req_w;
  logic [31:0] val_rf_data_w;
  logic        halt;
  logic [31:0] disp_data;
  logic [31:0] cnt_retired;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the instruction sitting in WB, plus the architectural side effects.
  bit          m_valid;
  bit          m_we;
  bit [4:0]    m_req;
  bit [31:0]   m_data;
  bit          m_sys;
  bit [31:0]   m_v0;
  bit [31:0]   m_a0;
  bit          m_halted;
  bit [31:0]   m_disp;
  bit [31:0]   m_cnt;

  pst_wb #(.SYSCALL_EXIT(EXIT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .mem_valid(mem_valid), .mem_ctl_rf_we(mem_ctl_rf_we),
    .mem_val_rf_req_w(mem_val_rf_req_w),
    .mem_sel_rf_w_pc_4(mem_sel_rf_w_pc_4), .mem_sel_rf_w_dm(mem_sel_rf_w_dm),
    .mem_pc_4(mem_pc_4), .mem_alu_data(mem_alu_data), .mem_dm_data(mem_dm_data),
    .mem_syscall_en(mem_syscall_en),
    .mem_rf_data_a(mem_rf_data_a), .mem_rf_data_b(mem_rf_data_b),
    .ctl_rf_we(ctl_rf_we), .val_rf_req_w(val_rf_req_w), .val_rf_data_w(val_rf_data_w),
    .halt(halt), .disp_data(disp_data), .cnt_retired(cnt_retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_req = 0; m_data = 0; m_sys = 0; m_v0 = 0; m_a0 = 0;
    m_halted = 0; m_disp = 0; m_cnt = 0;
  endtask

  // What one clock edge does to the machine, stated from the architectural rules.
  task automatic model_edge();
    if (en && !m_halted) begin
      if (m_valid) m_cnt = m_cnt + 1;
      if (m_valid && m_sys && m_v0 == EXIT) begin
        m_halted = 1;
        m_valid  = 0;
        m_we     = 0;
      end else begin
        if (m_valid && m_sys) m_disp = m_a0;
        m_valid = mem_valid;
        m_we    = mem_valid && mem_ctl_rf_we && (mem_val_rf_req_w != 0);
        m_req   = mem_val_rf_req_w;
        m_data  = mem_sel_rf_w_pc_4 ? mem_pc_4 : (mem_sel_rf_w_dm ? mem_dm_data : mem_alu_data);
        m_sys   = mem_syscall_en;
        m_v0    = mem_rf_data_a;
        m_a0    = mem_rf_data_b;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".we"}, 32'(ctl_rf_we), 32'(m_valid && m_we));
    if (!m_halted) begin
      check({tag, ".req"}, 32'(val_rf_req_w), 32'(m_req));
      check({tag, ".data"}, val_rf_data_w, m_data);
    end
    check({tag, ".halt"}, 32'(halt), 32'(m_halted));
    check({tag, ".disp"}, disp_data, m_disp);
`ifdef WB_RETIRE_CNT_EN
    check({tag, ".cnt"}, cnt_retired, m_cnt);
`else
    check({tag, ".cnt"}, cnt_retired, 32'd0);
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_mem(input bit valid, input bit we, input bit [4:0] req,
                         input bit sel_pc, input bit sel_dm, input bit [31:0] pc,
                         input bit [31:0] alu, input bit [31:0] dm,
                         input bit sys, input bit [31:0] a, input bit [31:0] b);
    mem_valid = valid; mem_ctl_rf_we = we; mem_val_rf_req_w = req;
    mem_sel_rf_w_pc_4 = sel_pc; mem_sel_rf_w_dm = sel_dm;
    mem_pc_4 = pc; mem_alu_data = alu; mem_dm_data = dm;
    mem_syscall_en = sys; mem_rf_data_a = a; mem_rf_data_b = b;
  endtask

  task automatic set_random();
    bit sys;
    bit [31:0] v0;
    sys = ($urandom_range(0, 9) == 0);
    v0  = $urandom_range(0, 15);
    if (v0 == EXIT) v0 = 32'd1;
    set_mem($urandom_range(0, 3) != 0, sys ? 1'b0 : 1'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
            sys, v0, $urandom);
  endtask

  initial begin
    model_reset();
    rst_n = 0;
    en    = 0;
    set_mem(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;

    en = 1;
    set_mem(1, 1, 8, 0, 0, 32'h100, 32'h1234, 32'h5555, 0, 0, 0);
    tick("alu");
    check("alu_lit.we", 32'(ctl_rf_we), 32'd1);
    check("alu_lit.req", 32'(val_rf_req_w), 32'd8);
    check("alu_lit.data", val_rf_data_w, 32'h1234);

    set_mem(1, 1, 5, 1, 1, 32'h3004, 32'h7777, 32'hBEEF, 0, 0, 0);
    tick("prio");
    check("prio_lit.data", val_rf_data_w, 32'h3004);

    set_mem(1, 1, 6, 0, 1, 32'h3008, 32'h7777, 32'hBEEF, 0, 0, 0);
    tick("dm");

    set_mem(1, 1, 0, 0, 0, 0, 32'h99, 0, 0, 0, 0);
    tick("zero");
    check("zero_lit.we", 32'(ctl_rf_we), 32'd0);

    set_mem(1, 1, 12, 0, 0, 0, 32'hABCD, 0, 0, 0, 0);
    tick("pre_stall");
    en = 0;
    set_mem(1, 1, 13, 0, 0, 0, 32'h1111, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall_lit.data", val_rf_data_w, 32'hABCD);
    en = 1;
    tick("unstall");

    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      set_random();
      tick("rand");
    end

    en = 1;
    set_mem(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'd1, 32'hCAFE);
    tick("sys_disp_load");
    set_mem(1, 1, 3, 0, 0, 0, 32'h42, 0, 0, 0, 0);
    tick("sys_disp_ret");
    check("disp_lit", disp_data, 32'hCAFE);

    set_mem(1, 0, 0, 0, 0, 0, 0, 0, 1, EXIT, 32'hDEAD);
    tick("exit_load");
    set_mem(1, 1, 9, 0, 0, 0, 32'h9999, 0, 0, 0, 0);
    tick("exit_ret");
    check("halt_lit", 32'(halt), 32'd1);
    check("halt_lit.we", 32'(ctl_rf_we), 32'd0);
    for (int i = 0; i < 10; i++) begin
      en = 1'($urandom);
      tick("halted");
    end

    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("rst_mid.halt", 32'(halt), 32'd0);
    check("rst_mid.disp", disp_data, 32'd0);
    check("rst_mid.cnt", cnt_retired, 32'd0);
    check("rst_mid.we", 32'(ctl_rf_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    en = 1;
    set_mem(1, 1, 9, 0, 0, 0, 32'h5A5A, 0, 0, 0, 0);
    tick("resume");
    check("resume_lit.we", 32'(ctl_rf_we), 32'd1);
    check("resume_lit.data", val_rf_data_w, 32'h5A5A);
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 3) != 0);
      set_random();
      tick("rand2");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
